alu_ctrl_mc: RTL and testbench

Multicycle-aware ALU control unit for the MIPS-lite datapath: decodes ALUOp plus full 6-bit funct into a widened ALU control code and sequences iterative multiply/divide operations. While a multiply/divide is in flight it stalls the front end, drives per-iteration step codes to the ALU, and pulses the HI/LO write enable at completion. Sits between the main control unit and the ALU/HI-LO datapath, replacing the purely combinational ALU control.

---
 rtl/alu_ctrl_pkg.sv | 34 +++
 rtl/alu_ctrl_mc_if.sv | 18 +
 rtl/alu_ctrl_dec.sv | 52 +++++
 rtl/alu_ctrl_mc.sv | 59 +++++
 tb/tb_alu_ctrl_mc.sv | 139 +++++++++++++
 5 files changed

// File: rtl/alu_ctrl_pkg.sv
// alu_ctrl_pkg: ALU control codes, funct constants, FSM state and mult/div op descriptor.
package alu_ctrl_pkg;
  localparam logic [3:0] ALU_AND   = 4'b0000;
  localparam logic [3:0] ALU_OR    = 4'b0001;
  localparam logic [3:0] ALU_ADD   = 4'b0010;
  localparam logic [3:0] ALU_SRL   = 4'b0011;
  localparam logic [3:0] ALU_SLL   = 4'b0100;
  localparam logic [3:0] ALU_SUB   = 4'b0110;
  localparam logic [3:0] ALU_SLT   = 4'b0111;
  localparam logic [3:0] ALU_MDMUL = 4'b1000;
  localparam logic [3:0] ALU_MDDIV = 4'b1001;
  localparam logic [3:0] ALU_NOR   = 4'b1100;
  localparam logic [3:0] ALU_XOR   = 4'b1101;
  localparam logic [5:0] F_ADD   = 6'b100000;
  localparam logic [5:0] F_ADDU  = 6'b100001;
  localparam logic [5:0] F_SUB   = 6'b100010;
  localparam logic [5:0] F_SUBU  = 6'b100011;
  localparam logic [5:0] F_AND   = 6'b100100;
  localparam logic [5:0] F_OR    = 6'b100101;
  localparam logic [5:0] F_XOR   = 6'b100110;
  localparam logic [5:0] F_NOR   = 6'b100111;
  localparam logic [5:0] F_SLT   = 6'b101010;
  localparam logic [5:0] F_SLL   = 6'b000000;
  localparam logic [5:0] F_SRL   = 6'b000010;
  localparam logic [5:0] F_MULT  = 6'b011000;
  localparam logic [5:0] F_MULTU = 6'b011001;
  localparam logic [5:0] F_DIV   = 6'b011010;
  localparam logic [5:0] F_DIVU  = 6'b011011;
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  typedef struct packed {
    logic div;
    logic sgn;
  } md_op_t;
endpackage

// File: rtl/alu_ctrl_mc_if.sv
// alu_ctrl_mc_if: decode inputs and ALU/mult-div/HI-LO control outputs of alu_ctrl_mc.
interface alu_ctrl_mc_if #(parameter int CTRL_W = 4);
  logic              valid_in;
  logic [1:0]        aluop;
  logic [5:0]        funct;
  logic [CTRL_W-1:0] gout;
  logic              md_start;
  logic              md_step;
  logic              md_div;
  logic              md_signed;
  logic              hilo_we;
  logic              stall;
  logic              ill_op;
  modport master(output valid_in, aluop, funct,
                 input gout, md_start, md_step, md_div, md_signed, hilo_we, stall, ill_op);
  modport slave(input valid_in, aluop, funct,
                output gout, md_start, md_step, md_div, md_signed, hilo_we, stall, ill_op);
endinterface

// File: rtl/alu_ctrl_dec.sv
// alu_ctrl_dec: combinational aluop/funct decode; ALUCTRL_DIV_EN makes div/divu legal mult/div ops.
module alu_ctrl_dec
  import alu_ctrl_pkg::*;
#(
  parameter int CTRL_W = 4
) (
  input  logic [1:0]        aluop,
  input  logic [5:0]        funct,
  output logic [CTRL_W-1:0] gout,
  output logic              is_md,
  output md_op_t            md,
  output logic              ill_op
);
  logic [3:0] code;
  always_comb begin
    code = ALU_ADD;
    is_md = 1'b0;
    md = '0;
    ill_op = 1'b0;
    case (aluop)
      2'b01: code = ALU_SUB;
      2'b11: code = ALU_OR;
      2'b10:
        case (funct)
          F_ADD, F_ADDU: code = ALU_ADD;
          F_SUB, F_SUBU: code = ALU_SUB;
          F_AND: code = ALU_AND;
          F_OR: code = ALU_OR;
          F_XOR: code = ALU_XOR;
          F_NOR: code = ALU_NOR;
          F_SLT: code = ALU_SLT;
          F_SLL: code = ALU_SLL;
          F_SRL: code = ALU_SRL;
          F_MULT, F_MULTU: begin
            code = ALU_MDMUL;
            is_md = 1'b1;
            md = '{div: 1'b0, sgn: ~funct[0]};
          end
`ifdef ALUCTRL_DIV_EN
          F_DIV, F_DIVU: begin
            code = ALU_MDDIV;
            is_md = 1'b1;
            md = '{div: 1'b1, sgn: ~funct[0]};
          end
`endif
          default: ill_op = 1'b1;
        endcase
      default: code = ALU_ADD;
    endcase
  end
  assign gout = CTRL_W'(code);
endmodule

// File: rtl/alu_ctrl_mc.sv
// alu_ctrl_mc: ALU control with iterative mult/div sequencing (IDLE/RUN/DONE), front-end stall and HI/LO write pulse.
module alu_ctrl_mc
  import alu_ctrl_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int CTRL_W = 4
) (
  input logic          clk,
  input logic          rst_n,
  alu_ctrl_mc_if.slave bus
);
  localparam int CNT_W = $clog2(DATA_W + 1);
  state_t            state;
  logic [CNT_W-1:0]  cnt;
  md_op_t            md_q;
  md_op_t            md_d;
  logic [CTRL_W-1:0] g_d;
  logic              is_md;
  logic              ill_d;
  logic              accept;
  alu_ctrl_dec #(.CTRL_W(CTRL_W)) u_dec (
    .aluop (bus.aluop),
    .funct (bus.funct),
    .gout  (g_d),
    .is_md (is_md),
    .md    (md_d),
    .ill_op(ill_d)
  );
  // rst_n gates the IDLE input paths so outputs drop the moment reset asserts
  assign accept = rst_n && state == IDLE && bus.valid_in && is_md;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= IDLE;
      cnt <= '0;
      md_q <= '0;
    end else
      case (state)
        IDLE: if (accept) begin
          state <= RUN;
          cnt <= CNT_W'(DATA_W);
          md_q <= md_d;
        end
        RUN: begin
          cnt <= cnt - CNT_W'(cnt != '0);
          state <= (cnt <= CNT_W'(1)) ? DONE : RUN;
        end
        default: state <= IDLE;
      endcase
  assign bus.md_start = accept;
  assign bus.stall = accept || state == RUN;
  assign bus.md_step = state == RUN;
  assign bus.hilo_we = state == DONE;
  assign bus.md_div = md_q.div;
  assign bus.md_signed = md_q.sgn;
  assign bus.ill_op = rst_n && state == IDLE && ill_d;
  assign bus.gout = !rst_n ? CTRL_W'(ALU_ADD) :
                    state == IDLE ? g_d :
                    CTRL_W'(md_q.div ? ALU_MDDIV : ALU_MDMUL);
endmodule

// File: tb/tb_alu_ctrl_mc.sv
// tb_alu_ctrl_mc: directed and random stimulus against a cycle-count reference model of alu_ctrl_mc.
module tb_alu_ctrl_mc;
  localparam int DATA_W = 32;
`ifdef ALUCTRL_DIV_EN
  localparam bit DIV_EN = 1'b1;
`else
  localparam bit DIV_EN = 1'b0;
`endif
  logic clk;
  logic rst_n;
  int tests = 0;
  int fails = 0;
  int ph = -1;
  logic ed = 1'b0;
  logic es = 1'b0;
  logic [5:0] ftab [11] = '{6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25, 6'h26, 6'h27, 6'h2a, 6'h00, 6'h02};
  logic [3:0] ctab [11] = '{4'h2, 4'h2, 4'h6, 4'h6, 4'h0, 4'h1, 4'hd, 4'hc, 4'h7, 4'h4, 4'h3};
  alu_ctrl_mc_if #(.CTRL_W(4)) bus ();
  alu_ctrl_mc #(.DATA_W(DATA_W), .CTRL_W(4)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );
  initial clk = 1'b0;
  always #5 clk = ~clk;
  task automatic chk(input string tag, input int got, input int exp);
    tests++;
    if (got != exp) begin
      fails++;
      $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, got, exp);
    end
  endtask
  task automatic ref_dec(input logic [1:0] a, input logic [5:0] f, output logic [3:0] c,
                         output logic m, output logic d, output logic s, output logic il);
    c = 4'h2; m = 1'b0; d = 1'b0; s = 1'b0; il = 1'b0;
    if (a == 2'b01) c = 4'h6;
    else if (a == 2'b11) c = 4'h1;
    else if (a == 2'b10) begin
      il = 1'b1;
      for (int i = 0; i < 11; i++) if (f == ftab[i]) begin c = ctab[i]; il = 1'b0; end
      if (f[5:2] == 4'b0110 && (DIV_EN || !f[1])) begin
        il = 1'b0; m = 1'b1; d = f[1]; s = !f[0];
      end
    end
  endtask
  task automatic drive(input logic v, input logic [1:0] a, input logic [5:0] f);
    bus.valid_in = v; bus.aluop = a; bus.funct = f;
  endtask
  task automatic check_zero(input string tag);
    chk({tag, "_gout"}, int'(bus.gout), 2);
    chk({tag, "_outs"}, int'({bus.md_start, bus.md_step, bus.md_div, bus.md_signed,
                              bus.hilo_we, bus.stall, bus.ill_op}), 0);
  endtask
  // ph: -1 idle, 1..DATA_W iterating, DATA_W+1 writing HI/LO
  task automatic cycle();
    logic [3:0] c;
    logic m, d, s, il, acc;
    acc = 1'b0;
    #4;
    if (ph < 0) begin
      ref_dec(bus.aluop, bus.funct, c, m, d, s, il);
      acc = bus.valid_in && m;
      if (!m) chk("gout", int'(bus.gout), int'(c));
      chk("stall", int'(bus.stall), int'(acc));
      chk("md_start", int'(bus.md_start), int'(acc));
      chk("md_step", int'(bus.md_step), 0);
      chk("hilo_we", int'(bus.hilo_we), 0);
      chk("ill_op", int'(bus.ill_op), int'(il));
    end else begin
      chk("gout_md", int'(bus.gout), ed ? 9 : 8);
      chk("stall_md", int'(bus.stall), int'(ph <= DATA_W));
      chk("md_step_md", int'(bus.md_step), int'(ph <= DATA_W));
      chk("hilo_we_md", int'(bus.hilo_we), int'(ph == DATA_W + 1));
      chk("md_start_md", int'(bus.md_start), 0);
      chk("ill_op_md", int'(bus.ill_op), 0);
      chk("md_div", int'(bus.md_div), int'(ed));
      chk("md_signed", int'(bus.md_signed), int'(es));
    end
    @(posedge clk);
    #1;
    if (ph < 0) begin
      if (acc) begin ph = 1; ed = d; es = s; end
    end else ph = (ph == DATA_W + 1) ? -1 : ph + 1;
  endtask
  initial begin
    rst_n = 1'b0;
    drive(1'b1, 2'b10, 6'h18);
    #2;
    check_zero("reset");
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    for (int i = 0; i < 11; i++) begin
      drive(1'b1, 2'b10, ftab[i]);
      cycle();
    end
    drive(1'b1, 2'b10, 6'h3f); cycle();
    drive(1'b1, 2'b00, 6'h3f); cycle();
    drive(1'b1, 2'b01, 6'h18); cycle();
    drive(1'b1, 2'b11, 6'h1a); cycle();
    drive(1'b1, 2'b10, 6'h18); cycle();
    bus.valid_in = 1'b0;
    repeat (DATA_W + 2) cycle();
    drive(1'b1, 2'b10, 6'h19);
    repeat (2 * (DATA_W + 2)) cycle();
    bus.valid_in = 1'b0;
    repeat (DATA_W + 2) cycle();
    drive(1'b1, 2'b10, 6'h1a); cycle();
    bus.valid_in = 1'b0;
    repeat (DATA_W + 2) cycle();
    drive(1'b1, 2'b10, 6'h1b); cycle();
    bus.valid_in = 1'b0;
    repeat (DATA_W + 2) cycle();
    drive(1'b1, 2'b10, 6'h18); cycle();
    bus.valid_in = 1'b0;
    repeat (9) cycle();
    chk("run_phase", ph, 10);
    #2;
    drive(1'b1, 2'b10, 6'h18);
    rst_n = 1'b0;
    #1;
    check_zero("midrun_reset");
    @(posedge clk);
    #1;
    drive(1'b0, 2'b10, 6'h18);
    rst_n = 1'b1;
    ph = -1; ed = 1'b0; es = 1'b0;
    repeat (DATA_W + 4) cycle();
    repeat (1500) begin
      bus.valid_in = 1'($urandom_range(1));
      bus.aluop = 2'($urandom_range(3));
      bus.funct = ($urandom_range(7) == 0) ? 6'(6'h18 + $urandom_range(3)) :
                  ($urandom_range(1) == 0) ? ftab[$urandom_range(10)] : 6'($urandom);
      cycle();
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
